// File: rtl/bin_to_bcd_seq.sv
// Sequential double-dabble converter: one input bit per cycle, unsigned binary to packed BCD.
// bcd_out/ovf are only rewritten at completion, so a downstream display never sees partial sums.
module bin_to_bcd_seq #(
    parameter int BIN_WIDTH  = 8,
    parameter int NUM_DIGITS = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [BIN_WIDTH-1:0]    bin_in,
    output logic [4*NUM_DIGITS-1:0] bcd_out,
    output logic                    busy,
    output logic                    done,
    output logic                    ovf
);
    localparam int D_CEIL = (BIN_WIDTH + 2) / 3;
    localparam int D_INT  = (NUM_DIGITS > D_CEIL) ? NUM_DIGITS : D_CEIL;
    localparam int SW     = 4 * D_INT;
    localparam int CW     = $clog2(BIN_WIDTH + 1);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t               state;
    logic [BIN_WIDTH-1:0] sreg;
    logic [SW-1:0]        scr;
    logic [SW-1:0]        adj;
    logic [CW-1:0]        cnt;
    logic                 ovf_c;

    // Per-digit add-3 correction ahead of each shift; carries never leave the nibble.
    for (genvar g = 0; g < D_INT; g++) begin : g_adj
        assign adj[4*g +: 4] = (scr[4*g +: 4] >= 4'd5) ? scr[4*g +: 4] + 4'd3 : scr[4*g +: 4];
    end

    // Scratch is sized for the full decimal value, so overflow is just "any upper digit set".
    if (D_INT > NUM_DIGITS) begin : g_ovf
        assign ovf_c = |scr[SW-1:4*NUM_DIGITS];
    end else begin : g_noovf
        assign ovf_c = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            sreg    <= '0;
            scr     <= '0;
            cnt     <= '0;
            bcd_out <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            ovf     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        sreg  <= bin_in;
                        scr   <= '0;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= SHIFT;
                    end
                end
                SHIFT: begin
                    {scr, sreg} <= {adj[SW-2:0], sreg, 1'b0};
                    cnt         <= cnt + CW'(1);
                    if (cnt == CW'(BIN_WIDTH - 1)) state <= DONE;
                end
                DONE: begin
                    ovf     <= ovf_c;
                    bcd_out <= ovf_c ? {NUM_DIGITS{4'h9}} : scr[4*NUM_DIGITS-1:0];
                    done    <= 1'b1;
                    busy    <= 1'b0;
                    state   <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Randomized and directed bench for bin_to_bcd_seq across three parameter sets,
// compared against a decimal-arithmetic reference.
module tb_bin_to_bcd_seq;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // dut0: 8b/2 digits, dut1: 8b/3 digits, dut2: 10b/4 digits
    logic        st [3];
    logic [15:0] bn [3];
    logic [15:0] bc [3];
    logic        bsy[3], dn[3], ov[3];
    logic [7:0]  bcd0;
    logic [11:0] bcd1;
    logic [15:0] bcd2;
    logic        busy0, busy1, busy2, done0, done1, done2, ovf0, ovf1, ovf2;
    int          bw [3] = '{8, 8, 10};
    int          nd [3] = '{2, 3, 4};

    bin_to_bcd_seq #(.BIN_WIDTH(8), .NUM_DIGITS(2)) u0 (
        .clk(clk), .rst(rst), .start(st[0]), .bin_in(bn[0][7:0]),
        .bcd_out(bcd0), .busy(busy0), .done(done0), .ovf(ovf0));
    bin_to_bcd_seq #(.BIN_WIDTH(8), .NUM_DIGITS(3)) u1 (
        .clk(clk), .rst(rst), .start(st[1]), .bin_in(bn[1][7:0]),
        .bcd_out(bcd1), .busy(busy1), .done(done1), .ovf(ovf1));
    bin_to_bcd_seq #(.BIN_WIDTH(10), .NUM_DIGITS(4)) u2 (
        .clk(clk), .rst(rst), .start(st[2]), .bin_in(bn[2][9:0]),
        .bcd_out(bcd2), .busy(busy2), .done(done2), .ovf(ovf2));

    always_comb begin
        bc[0] = {8'h0, bcd0}; bc[1] = {4'h0, bcd1}; bc[2] = bcd2;
        bsy[0] = busy0; bsy[1] = busy1; bsy[2] = busy2;
        dn[0] = done0;  dn[1] = done1;  dn[2] = done2;
        ov[0] = ovf0;   ov[1] = ovf1;   ov[2] = ovf2;
    end

    // Reference: plain decimal digits, saturated to all nines when too large.
    function automatic logic [16:0] ref_conv(input int unsigned v, input int ndig);
        logic [15:0] r = '0;
        int unsigned lim = 1;
        int unsigned t = v;
        for (int i = 0; i < ndig; i++) lim = lim * 10;
        if (v >= lim) begin
            for (int i = 0; i < ndig; i++) r[4*i +: 4] = 4'd9;
            return {1'b1, r};
        end
        for (int i = 0; i < ndig; i++) begin
            r[4*i +: 4] = 4'(t % 10);
            t = t / 10;
        end
        return {1'b0, r};
    endfunction

    task automatic step();
        @(posedge clk); #1;
    endtask

    // Issue one start on dut d, return result and number of edges from acceptance to done.
    task automatic convert(input int d, input int unsigned v, output logic [16:0] res,
                           output int lat);
        st[d] = 1'b1; bn[d] = 16'(v);
        step();
        st[d] = 1'b0; bn[d] = 16'($urandom);
        lat = -1;
        for (int i = 1; i <= 40; i++) begin
            step();
            if (dn[d]) begin lat = i; break; end
        end
        res = {ov[d], bc[d]};
    endtask

    task automatic test_reset();
        for (int d = 0; d < 3; d++) begin
            checks++;
            if ({bc[d], bsy[d], dn[d], ov[d]} !== 19'h0) begin
                errors++;
                $display("FAIL reset dut%0d: bcd=%h busy=%b done=%b ovf=%b, expected all zero",
                         d, bc[d], bsy[d], dn[d], ov[d]);
            end
        end
    endtask

    task automatic test_basic_42();
        logic [15:0] prior = bc[0];
        st[0] = 1'b1; bn[0] = 16'd42;
        step();                       // edge T
        st[0] = 1'b0; bn[0] = 16'd200;
        for (int i = 0; i <= 9; i++) begin
            if (i > 0) step();
            checks++;
            if (i < 9) begin
                if (bsy[0] !== 1'b1 || dn[0] !== 1'b0 || bc[0] !== prior) begin
                    errors++;
                    $display("FAIL basic42 T+%0d: busy=%b done=%b bcd=%h, expected 1 0 %h",
                             i, bsy[0], dn[0], bc[0], prior);
                end
            end else if (bsy[0] !== 1'b0 || dn[0] !== 1'b1 || bc[0] !== 16'h42 || ov[0] !== 1'b0) begin
                errors++;
                $display("FAIL basic42 T+9: busy=%b done=%b bcd=%h ovf=%b, expected 0 1 0042 0",
                         bsy[0], dn[0], bc[0], ov[0]);
            end
        end
        step();
        checks++;
        if (dn[0] !== 1'b0 || bc[0] !== 16'h42) begin
            errors++;
            $display("FAIL basic42 hold: done=%b bcd=%h, expected 0 0042", dn[0], bc[0]);
        end
    endtask

    task automatic check_conv(input string nm, input int d, input int unsigned v);
        logic [16:0] res, exp;
        int lat;
        exp = ref_conv(v, nd[d]);
        convert(d, v, res, lat);
        checks++;
        if (res !== exp || lat != bw[d] + 1) begin
            errors++;
            $display("FAIL %s dut%0d v=%0d: ovf/bcd=%h lat=%0d, expected %h lat=%0d",
                     nm, d, v, res, lat, exp, bw[d] + 1);
        end
        step();
    endtask

    task automatic test_boundaries();
        check_conv("zero", 0, 0);
        check_conv("max99", 0, 99);
        check_conv("ovf100", 0, 100);
        check_conv("ovf255", 0, 255);
        check_conv("nd3_255", 1, 255);
        check_conv("w10_1023", 2, 1023);
        check_conv("w10_zero", 2, 0);
    endtask

    task automatic test_random();
        for (int n = 0; n < 12; n++) begin
            for (int d = 0; d < 3; d++)
                check_conv("random", d, $urandom_range(0, (1 << bw[d]) - 1));
        end
    endtask

    task automatic test_back_to_back();
        int pulses = 0;
        int lat = -1;
        st[0] = 1'b1; bn[0] = 16'd42;
        step();                       // edge T
        st[0] = 1'b0;
        for (int i = 1; i <= 9; i++) begin
            if (i == 2) begin st[0] = 1'b1; bn[0] = 16'd17; end
            if (i == 3) st[0] = 1'b0;
            step();
            if (dn[0]) pulses++;
        end
        checks++;
        if (pulses != 1 || dn[0] !== 1'b1 || bc[0] !== 16'h42) begin
            errors++;
            $display("FAIL busy_ignore: pulses=%0d done=%b bcd=%h, expected 1 1 0042",
                     pulses, dn[0], bc[0]);
        end
        // Start in the done cycle itself
        st[0] = 1'b1; bn[0] = 16'd17;
        step();
        st[0] = 1'b0;
        for (int i = 2; i <= 30; i++) begin
            step();
            if (dn[0]) begin lat = i; break; end
        end
        checks++;
        if (lat != 10 || bc[0] !== 16'h17) begin
            errors++;
            $display("FAIL back_to_back: done after %0d cycles bcd=%h, expected 10 0017", lat, bc[0]);
        end
        step();
    endtask

    task automatic test_reset_mid();
        logic [16:0] res;
        int lat;
        int seen = 0;
        st[0] = 1'b1; bn[0] = 16'd77;
        step();                       // edge T
        st[0] = 1'b0;
        repeat (3) step();
        #3 rst = 1'b1;                // between edges T+3 and T+4
        #1;
        checks++;
        if ({bc[0], bsy[0], dn[0], ov[0]} !== 19'h0) begin
            errors++;
            $display("FAIL reset_mid: bcd=%h busy=%b done=%b ovf=%b, expected all zero",
                     bc[0], bsy[0], dn[0], ov[0]);
        end
        repeat (2) step();
        rst = 1'b0;
        for (int i = 0; i < 12; i++) begin
            step();
            if (dn[0] || bsy[0]) seen++;
        end
        checks++;
        if (seen != 0 || bc[0] !== 16'h0) begin
            errors++;
            $display("FAIL reset_abort: activity=%0d bcd=%h, expected 0 0000", seen, bc[0]);
        end
        convert(0, 77, res, lat);
        checks++;
        if (res !== 17'h00077 || lat != 9) begin
            errors++;
            $display("FAIL reset_restart: ovf/bcd=%h lat=%0d, expected 00077 9", res, lat);
        end
        step();
    endtask

    task automatic test_sustained();
        int unsigned v = $urandom_range(0, 99);
        logic [16:0] exp = ref_conv(v, 2);
        int last = -1;
        int npulse = 0;
        st[0] = 1'b1; bn[0] = 16'(v);
        for (int c = 0; c < 60; c++) begin
            step();
            if (dn[0]) begin
                npulse++;
                checks++;
                if ({ov[0], bc[0]} !== exp || (last >= 0 && c - last != 10)) begin
                    errors++;
                    $display("FAIL sustained c=%0d: ovf/bcd=%h gap=%0d, expected %h gap=10",
                             c, {ov[0], bc[0]}, c - last, exp);
                end
                last = c;
            end else if (last >= 0) begin
                checks++;
                if ({ov[0], bc[0]} !== exp) begin
                    errors++;
                    $display("FAIL sustained_hold c=%0d: ovf/bcd=%h, expected %h",
                             c, {ov[0], bc[0]}, exp);
                end
            end
        end
        st[0] = 1'b0;
        checks++;
        if (npulse < 5) begin
            errors++;
            $display("FAIL sustained_count: %0d pulses, expected at least 5", npulse);
        end
        repeat (12) step();
    endtask

    initial begin
        for (int d = 0; d < 3; d++) begin st[d] = 1'b0; bn[d] = '0; end
        repeat (3) step();
        test_reset();
        rst = 1'b0;
        step();
        test_basic_42();
        test_boundaries();
        test_random();
        test_back_to_back();
        test_reset_mid();
        test_sustained();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
